// File: rtl/tx_frame_buffer.sv
// Store-and-forward transmit frame buffer: bytes land in a circular store, whole frames
// are committed through a length queue, then replayed downstream one byte per ack.
module tx_frame_buffer #(
  parameter int DATA_AW    = 11,
  parameter int LEN_AW     = 4,
  parameter int MAX_LEN    = 1500,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_byte_val,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_eof,
  output logic              o_ari_val,
  output logic              o_ari_sof,
  output logic              o_ari_eof,
  output logic [1:0]        o_ari_be,
  output logic [31:0]       o_ari_data,
  input  logic              i_ari_ack,
  output logic [14:0]       o_ari_frame_len,
  output logic              o_ari_frame_len_val,
  output logic              o_drop_pulse,
  output logic [15:0]       o_drop_cnt,
  output logic [LEN_AW:0]   o_frames_pending
);

  localparam int          PW        = DATA_AW + 1;
  localparam int          QW        = LEN_AW + 1;
  localparam logic [14:0] MAX_LEN_L = 15'(MAX_LEN);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0] Q_ONE   = {{(QW-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Storage arrays
  logic [7:0]  r_store [2**DATA_AW];
  logic [14:0] r_lq    [2**LEN_AW];

  // Input (write) side
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_frm_start;
  logic [14:0]   r_cur_len;
  logic [15:0]   r_gap_cnt;
  logic          r_bad;
  logic [QW-1:0] r_lq_wr;
  logic          r_drop_pulse;
  logic [15:0]   r_drop_cnt;

  // Output (read) side
  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_rd_ptr;
  logic [QW-1:0] r_lq_rd;
  logic [QW-1:0] r_lq_wr_vis;
  logic [14:0]   r_frame_len;
  logic [14:0]   r_remaining;
  logic          r_sof;
  logic [QW-1:0] r_pending;

  logic          w_store_full;
  logic          w_lq_full;
  logic          w_bad_now;
  logic          w_write;
  logic          w_close_byte;
  logic          w_close_gap;
  logic          w_close;
  logic [14:0]   w_close_len;
  logic          w_drop;
  logic          w_commit;
  logic [PW-1:0] w_wr_ptr_inc;

  logic [QW-1:0] w_lq_rd_next;
  logic          w_avail;
  logic          w_avail_after_pop;
  logic          w_last;
  logic          w_ack;
  logic          w_eof_ack;
  logic          w_load;
  logic [QW-1:0] w_load_ptr;
  logic [14:0]   w_load_len;

  // ---------------------------------------------------------------------------
  // Write side: uncommitted bytes count as occupied, so fullness is judged
  // against the working write pointer rather than the committed frame start.
  // ---------------------------------------------------------------------------
  assign w_store_full = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                        (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign w_lq_full    = (r_lq_wr[QW-1] != r_lq_rd[QW-1]) &&
                        (r_lq_wr[QW-2:0] == r_lq_rd[QW-2:0]);

  assign w_bad_now    = r_bad || (i_byte_val && w_store_full);
  assign w_write      = i_byte_val && !w_bad_now;
  assign w_close_byte = i_byte_val && (i_byte_eof || (r_cur_len + 15'd1 == MAX_LEN_L));
  assign w_close_gap  = !i_byte_val && (r_cur_len != 15'd0) && (r_gap_cnt == GAP_LAST);
  assign w_close      = w_close_byte || w_close_gap;
  assign w_close_len  = i_byte_val ? r_cur_len + 15'd1 : r_cur_len;
  assign w_drop       = w_close && (w_bad_now || w_lq_full);
  assign w_commit     = w_close && !w_drop;
  assign w_wr_ptr_inc = w_write ? r_wr_ptr + PTR_ONE : r_wr_ptr;

  // NOTE: the data and length arrays carry no reset; every read is gated by
  // pointers that are reset, so stale contents can never reach the outputs.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_store[r_wr_ptr[DATA_AW-1:0]] <= i_byte_data;
    end
    if (w_commit) begin
      r_lq[r_lq_wr[LEN_AW-1:0]] <= w_close_len;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_frm_start  <= '0;
      r_cur_len    <= '0;
      r_gap_cnt    <= '0;
      r_bad        <= 1'b0;
      r_lq_wr      <= '0;
      r_lq_wr_vis  <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_close) begin
        r_cur_len <= '0;
        r_gap_cnt <= '0;
        r_bad     <= 1'b0;
        r_wr_ptr  <= w_drop ? r_frm_start : w_wr_ptr_inc;
        if (w_commit) begin
          r_frm_start <= w_wr_ptr_inc;
        end
      end else begin
        r_wr_ptr <= w_wr_ptr_inc;
        r_bad    <= w_bad_now;
        if (i_byte_val) begin
          r_cur_len <= r_cur_len + 15'd1;
          r_gap_cnt <= '0;
        end else if (r_cur_len != 15'd0) begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
        end
      end
      if (w_commit) begin
        r_lq_wr <= r_lq_wr + Q_ONE;
      end
      // Read side sees commits one cycle late, after the store write has landed.
      r_lq_wr_vis  <= r_lq_wr;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: two-state presenter, zero-bubble between bytes and frames.
  // ---------------------------------------------------------------------------
  assign w_lq_rd_next      = r_lq_rd + Q_ONE;
  assign w_avail           = (r_lq_wr_vis != r_lq_rd);
  assign w_avail_after_pop = (r_lq_wr_vis != w_lq_rd_next);
  assign w_last            = (r_remaining == 15'd1);
  assign w_ack             = (r_state == ST_PRESENT) && i_ari_ack;
  assign w_eof_ack         = w_ack && w_last;
  assign w_load_len        = r_lq[w_load_ptr[LEN_AW-1:0]];

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state        = r_state;
    w_load              = 1'b0;
    w_load_ptr          = r_lq_rd;
    o_ari_val           = 1'b0;
    o_ari_sof           = 1'b0;
    o_ari_eof           = 1'b0;
    o_ari_frame_len_val = 1'b0;
    o_ari_frame_len     = '0;
    o_ari_data          = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_avail) begin
          w_next_state = ST_PRESENT;
          w_load       = 1'b1;
        end
      end
      ST_PRESENT: begin
        o_ari_val           = 1'b1;
        o_ari_sof           = r_sof;
        o_ari_eof           = w_last;
        o_ari_frame_len_val = 1'b1;
        o_ari_frame_len     = r_frame_len;
        o_ari_data          = {24'h0, r_store[r_rd_ptr[DATA_AW-1:0]]};
        if (i_ari_ack && w_last) begin
          w_load_ptr = w_lq_rd_next;
          if (w_avail_after_pop) begin
            w_load = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_ptr    <= '0;
      r_lq_rd     <= '0;
      r_frame_len <= '0;
      r_remaining <= '0;
      r_sof       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_ack) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_remaining <= r_remaining - 15'd1;
        r_sof       <= 1'b0;
      end
      if (w_eof_ack) begin
        r_lq_rd <= w_lq_rd_next;
      end
      // A load (new frame) takes priority over the per-byte updates above.
      if (w_load) begin
        r_frame_len <= w_load_len;
        r_remaining <= w_load_len;
        r_sof       <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      case ({w_commit, w_eof_ack})
        2'b10:   r_pending <= r_pending + Q_ONE;
        2'b01:   r_pending <= r_pending - Q_ONE;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_ari_be         = 2'd0;
  assign o_drop_pulse     = r_drop_pulse;
  assign o_drop_cnt       = r_drop_cnt;
  assign o_frames_pending = r_pending;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Scoreboard bench for tx_frame_buffer: stimulus pushes expected bytes, a negedge
// monitor pops and compares every byte the DUT hands over on an ack.
module tb_tx_frame_buffer;

  localparam int DATA_AW    = 4;
  localparam int LEN_AW     = 2;
  localparam int MAX_LEN    = 8;
  localparam int GAP_CYCLES = 10;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_byte_val = 1'b0;
  logic [7:0]        i_byte_data = 8'h00;
  logic              i_byte_eof = 1'b0;
  logic              o_ari_val;
  logic              o_ari_sof;
  logic              o_ari_eof;
  logic [1:0]        o_ari_be;
  logic [31:0]       o_ari_data;
  logic              i_ari_ack = 1'b0;
  logic [14:0]       o_ari_frame_len;
  logic              o_ari_frame_len_val;
  logic              o_drop_pulse;
  logic [15:0]       o_drop_cnt;
  logic [LEN_AW:0]   o_frames_pending;

  tx_frame_buffer #(
    .DATA_AW    (DATA_AW),
    .LEN_AW     (LEN_AW),
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_byte_val          (i_byte_val),
    .i_byte_data         (i_byte_data),
    .i_byte_eof          (i_byte_eof),
    .o_ari_val           (o_ari_val),
    .o_ari_sof           (o_ari_sof),
    .o_ari_eof           (o_ari_eof),
    .o_ari_be            (o_ari_be),
    .o_ari_data          (o_ari_data),
    .i_ari_ack           (i_ari_ack),
    .o_ari_frame_len     (o_ari_frame_len),
    .o_ari_frame_len_val (o_ari_frame_len_val),
    .o_drop_pulse        (o_drop_pulse),
    .o_drop_cnt          (o_drop_cnt),
    .o_frames_pending    (o_frames_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic [14:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d0, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = d0 + 8'(i);
      e.sof  = (i == 0);
      e.eof  = (i == n - 1);
      e.len  = 15'(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic eof);
    i_byte_val  = 1'b1;
    i_byte_data = d;
    i_byte_eof  = eof;
    @(posedge i_clk);
    #1;
    i_byte_val  = 1'b0;
    i_byte_eof  = 1'b0;
    i_byte_data = 8'h00;
  endtask

  // Sends n consecutive bytes d0, d0+1, ...; optionally eof on the last one.
  task automatic send_frame(input logic [7:0] d0, input int n, input bit with_eof,
                            input bit expect_out);
    if (expect_out) expect_frame(d0, n);
    for (int i = 0; i < n; i++) send_byte(d0 + 8'(i), with_eof && (i == n - 1));
  endtask

  task automatic wait_val(input int max_cycles);
    int n = 0;
    while (!o_ari_val && n < max_cycles) begin
      @(negedge i_clk);
      n++;
    end
    check("wait_val", o_ari_val, 1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || o_ari_val) && n < max_cycles) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: every acked byte must match the head of the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_ari_val && i_ari_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got=%0h expected=none", o_ari_data);
      end else begin
        e = exp_q.pop_front();
        check("ari_data", o_ari_data, {24'h0, e.data});
        check("ari_sof", o_ari_sof, e.sof);
        check("ari_eof", o_ari_eof, e.eof);
        check("ari_len", o_ari_frame_len, e.len);
        check("ari_len_val", o_ari_frame_len_val, 1);
        check("ari_be", o_ari_be, 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_flags", {o_ari_val, o_ari_sof, o_ari_eof, o_ari_frame_len_val, o_drop_pulse}, 0);
    check("rst_data", o_ari_data, 0);
    check("rst_len", o_ari_frame_len, 0);
    check("rst_pending", o_frames_pending, 0);
    check("rst_drop_cnt", o_drop_cnt, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // A1..A3, eof on A3: latency, sof hold before ack, ack 3 cycles after val
    send_frame(8'hA1, 3, 1'b1, 1'b1);
    @(negedge i_clk); check("t1_val_e0", o_ari_val, 0);
    @(negedge i_clk); check("t1_val_e1", o_ari_val, 0);
    @(negedge i_clk);
    check("t1_val_e2", o_ari_val, 1);
    check("t1_sof", o_ari_sof, 1);
    check("t1_eof", o_ari_eof, 0);
    check("t1_len", o_ari_frame_len, 3);
    check("t1_len_val", o_ari_frame_len_val, 1);
    check("t1_pending", o_frames_pending, 1);
    repeat (2) begin
      @(negedge i_clk);
      check("t1_sof_hold", o_ari_sof, 1);
      check("t1_len_hold", o_ari_frame_len, 3);
    end
    @(posedge i_clk);
    #1 i_ari_ack = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("t1_val_after", o_ari_val, 0);
    check("t1_pending_after", o_frames_pending, 0);
    check("t1_idle_data", o_ari_data, 0);

    // Two committed frames (2 and 4 bytes), then ack tied high
    i_ari_ack = 1'b0;
    send_frame(8'hB1, 2, 1'b1, 1'b1);
    send_frame(8'hC1, 4, 1'b1, 1'b1);
    @(negedge i_clk);
    check("t2_pending2", o_frames_pending, 2);
    check("t2_len_first", o_ari_frame_len, 2);
    @(posedge i_clk);
    #1 i_ari_ack = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("t2_first_eof", o_ari_eof, 1);
    check("t2_pending_pre", o_frames_pending, 2);
    @(posedge i_clk);
    @(negedge i_clk);
    check("t2_next_val", o_ari_val, 1);
    check("t2_next_sof", o_ari_sof, 1);
    check("t2_next_len", o_ari_frame_len, 4);
    check("t2_pending1", o_frames_pending, 1);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check("t2_pending0", o_frames_pending, 0);
    check("t2_val_end", o_ari_val, 0);

    // 5 bytes then silence: gap closure on the 10th idle edge
    send_frame(8'hD1, 5, 1'b0, 1'b1);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk); check("t3_no_early_close", o_frames_pending, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("t3_commit", o_frames_pending, 1);
    check("t3_val_c0", o_ari_val, 0);
    @(posedge i_clk);
    @(negedge i_clk); check("t3_val_c1", o_ari_val, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("t3_val_c2", o_ari_val, 1);
    check("t3_len", o_ari_frame_len, 5);
    drain(30);

    // MAX_LEN closure: 10 bytes with eof on 10th -> 8 + 2; eof on the 8th -> one frame
    expect_frame(8'h50, 8);
    expect_frame(8'h58, 2);
    send_frame(8'h50, 10, 1'b1, 1'b0);
    drain(40);
    send_frame(8'h60, 8, 1'b1, 1'b1);
    drain(40);
    check("t4_drop_cnt", o_drop_cnt, 0);
    check("t4_pending", o_frames_pending, 0);

    // Store overflow: two 8-byte frames fill the 16-byte store, next frame dropped
    i_ari_ack = 1'b0;
    send_frame(8'h70, 8, 1'b0, 1'b1);
    send_frame(8'h80, 8, 1'b1, 1'b1);
    send_frame(8'h90, 4, 1'b1, 1'b0);
    @(negedge i_clk);
    check("t5_drop_pulse", o_drop_pulse, 1);
    check("t5_drop_cnt", o_drop_cnt, 1);
    check("t5_pending", o_frames_pending, 2);
    @(negedge i_clk);
    check("t5_drop_pulse_end", o_drop_pulse, 0);
    i_ari_ack = 1'b1;
    drain(60);
    send_frame(8'h31, 4, 1'b1, 1'b1);
    drain(20);
    check("t5_drop_cnt_hold", o_drop_cnt, 1);

    // Length-queue overflow: four 1-byte frames fit, the fifth is dropped
    i_ari_ack = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(8'hC0 + 8'(k), 1, 1'b1, 1'b1);
    send_frame(8'hC4, 1, 1'b1, 1'b0);
    @(negedge i_clk);
    check("t6_drop_pulse", o_drop_pulse, 1);
    check("t6_drop_cnt", o_drop_cnt, 2);
    check("t6_pending", o_frames_pending, 4);
    i_ari_ack = 1'b1;
    drain(40);

    // Asynchronous reset while presenting with three frames pending
    i_ari_ack = 1'b0;
    send_frame(8'hE1, 2, 1'b1, 1'b0);
    send_frame(8'hE3, 2, 1'b1, 1'b0);
    send_frame(8'hE5, 2, 1'b1, 1'b0);
    wait_val(10);
    @(negedge i_clk);
    check("t7_pending3", o_frames_pending, 3);
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("t7_rst_flags", {o_ari_val, o_ari_sof, o_ari_eof, o_ari_frame_len_val}, 0);
    check("t7_rst_data", o_ari_data, 0);
    check("t7_rst_pending", o_frames_pending, 0);
    check("t7_rst_drop_cnt", o_drop_cnt, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    i_ari_ack = 1'b1;
    send_frame(8'h41, 3, 1'b1, 1'b1);
    drain(20);
    check("t7_pending_end", o_frames_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
